// File: rtl/conv_engine_mc.sv
// conv_engine_mc: multi-channel KxK convolution engine.
//   Walks the output feature map row-major. For each output pixel it fetches
//   the KxK input window one tap per cycle from image SRAM (1-cycle read
//   latency), accumulates NUM_UNITS output channels in parallel, requantises
//   (arithmetic shift + saturation, optional ReLU) and offers the result on a
//   valid/ready port.
// Optional feature macro: ZERO_PAD_EN -- honour cfg_pad (1-pixel zero border).
//   Without it cfg_pad is ignored and only valid windows are computed.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_start                1-cycle start pulse (ignored while busy / in DONE)
//   i_cfg_*                layer config, latched on accepted start
//   i_w_flat               signed weights [u][ky][kx], unit 0 in the LSBs
//   o_img_rd_en/_addr      image SRAM read port, i_img_rd_data one cycle later
//   o_out_valid/i_out_ready/o_out_data/o_out_addr   output pixel stream
//   o_busy, o_done         layer status

// Per-channel MAC lane: accumulator plus requantiser.
module conv_mac_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_W      = 20
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_pix,
    input  logic [DATA_WIDTH-1:0] i_wgt,
    input  logic [3:0]            i_shift,
    input  logic                  i_relu,
    output logic [DATA_WIDTH-1:0] o_q
);
    localparam int PW = 2*DATA_WIDTH + 1;
    localparam logic signed [ACC_W-1:0] UMAX = ACC_W'((1 << DATA_WIDTH) - 1);
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (DATA_WIDTH-1)) - 1);
    localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-(1 << (DATA_WIDTH-1)));

    logic signed [ACC_W-1:0]    r_acc;
    logic signed [DATA_WIDTH:0] w_pix_s;
    logic signed [DATA_WIDTH-1:0] w_wgt_s;
    logic signed [PW-1:0]       w_prod;
    logic signed [ACC_W-1:0]    w_prod_x;
    logic signed [ACC_W-1:0]    w_r;

    // pixel is unsigned: one zero bit makes it a non-negative signed operand
    assign w_pix_s  = {1'b0, i_pix};
    assign w_wgt_s  = i_wgt;
    assign w_prod   = PW'(w_pix_s) * PW'(w_wgt_s);
    assign w_prod_x = ACC_W'(w_prod);
    assign w_r      = r_acc >>> i_shift;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) r_acc <= '0;
        else if (i_en)      r_acc <= r_acc + w_prod_x;
    end

    always_comb begin
        o_q = w_r[DATA_WIDTH-1:0];
        if (i_relu) begin
            if (w_r[ACC_W-1])   o_q = '0;
            else if (w_r > UMAX) o_q = '1;
        end else begin
            if (w_r > SMAX)      o_q = SMAX[DATA_WIDTH-1:0];
            else if (w_r < SMIN) o_q = SMIN[DATA_WIDTH-1:0];
        end
    end
endmodule

module conv_engine_mc #(
    parameter int K_H        = 3,
    parameter int K_W        = 3,
    parameter int MAX_H      = 16,
    parameter int MAX_W      = 15,
    parameter int NUM_UNITS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_W      = 20,
    parameter int ADDR_W     = 8
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_start,
    input  logic [4:0]                            i_cfg_in_w,
    input  logic [4:0]                            i_cfg_in_h,
    input  logic                                  i_cfg_stride,
    input  logic [3:0]                            i_cfg_shift,
    input  logic                                  i_cfg_relu,
    input  logic                                  i_cfg_pad,
    input  logic [NUM_UNITS*K_H*K_W*DATA_WIDTH-1:0] i_w_flat,
    output logic                                  o_img_rd_en,
    output logic [ADDR_W-1:0]                     o_img_rd_addr,
    input  logic [DATA_WIDTH-1:0]                 i_img_rd_data,
    output logic                                  o_out_valid,
    input  logic                                  i_out_ready,
    output logic [NUM_UNITS*DATA_WIDTH-1:0]       o_out_data,
    output logic [ADDR_W-1:0]                     o_out_addr,
    output logic                                  o_busy,
    output logic                                  o_done
);
    localparam int TAPS  = K_H*K_W;
    localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int KY_W  = (K_H > 1) ? $clog2(K_H) : 1;
    localparam int KX_W  = (K_W > 1) ? $clog2(K_W) : 1;
    localparam int CW    = $clog2(MAX_H + 2) + 2;   // padded coords + stride headroom
    localparam logic [KY_W-1:0] KY_LAST = KY_W'(K_H - 1);
    localparam logic [KX_W-1:0] KX_LAST = KX_W'(K_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUT, S_DONE} state_t;

    // tap issued last cycle; its read data arrives this cycle
    typedef struct packed {
        logic             vld;
        logic             rd;
        logic [IDX_W-1:0] idx;
    } tap_t;

    state_t r_state, w_next;
    tap_t   r_tap;

    logic            r_stride, r_relu, r_pad, r_empty;
    logic [3:0]      r_shift;
    logic [CW-1:0]   r_ih, r_iw, r_oh_m1, r_ow_m1;
    logic [CW-1:0]   r_orow, r_ocol;
    logic [KY_W-1:0] r_ky;
    logic [KX_W-1:0] r_kx;
    logic [IDX_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_pix;

    // ---------------- config decode at start ----------------
    logic          w_pad_in, w_empty;
    logic [CW-1:0] w_ih, w_iw, w_oh_m1, w_ow_m1;
`ifdef ZERO_PAD_EN
    assign w_pad_in = i_cfg_pad;
`else
    logic w_unused_pad;
    assign w_pad_in     = 1'b0;
    assign w_unused_pad = i_cfg_pad;
`endif
    assign w_ih    = CW'(i_cfg_in_h) + (w_pad_in ? CW'(2) : CW'(0));
    assign w_iw    = CW'(i_cfg_in_w) + (w_pad_in ? CW'(2) : CW'(0));
    assign w_empty = (w_ih < CW'(K_H)) || (w_iw < CW'(K_W));
    // last output index = (i - K) / S
    assign w_oh_m1 = i_cfg_stride ? ((w_ih - CW'(K_H)) >> 1) : (w_ih - CW'(K_H));
    assign w_ow_m1 = i_cfg_stride ? ((w_iw - CW'(K_W)) >> 1) : (w_iw - CW'(K_W));

    // ---------------- tap address ----------------
    logic [CW-1:0] w_y, w_x, w_ry, w_rx;
    logic          w_tap_pad, w_last_tap, w_last_pix, w_tap_vld;
    assign w_y = (r_stride ? {r_orow[CW-2:0], 1'b0} : r_orow) + CW'(r_ky);
    assign w_x = (r_stride ? {r_ocol[CW-2:0], 1'b0} : r_ocol) + CW'(r_kx);
    assign w_tap_pad = r_pad && (w_y == '0 || w_y == r_ih - CW'(1) ||
                                 w_x == '0 || w_x == r_iw - CW'(1));
    // padded-frame coords shift back by one to address the real image
    assign w_ry = r_pad ? w_y - CW'(1) : w_y;
    assign w_rx = r_pad ? w_x - CW'(1) : w_x;
    assign w_last_tap = (r_ky == KY_LAST) && (r_kx == KX_LAST);
    assign w_last_pix = (r_orow == r_oh_m1) && (r_ocol == r_ow_m1);
    assign o_img_rd_addr = o_img_rd_en ? ADDR_W'(int'(w_ry) * MAX_W + int'(w_rx)) : '0;

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_tap_vld   = 1'b0;
        o_img_rd_en = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_FETCH;
            S_FETCH: begin
                o_busy = 1'b1;
                if (r_empty) w_next = S_DONE;
                else begin
                    w_tap_vld   = 1'b1;
                    o_img_rd_en = ~w_tap_pad;
                    if (w_last_tap) w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                o_busy = 1'b1;
                w_next = S_OUT;
            end
            S_OUT: begin
                o_busy      = 1'b1;
                o_out_valid = 1'b1;
                if (i_out_ready) w_next = w_last_pix ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- counters / config ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tap    <= '0;
            r_stride <= 1'b0; r_relu <= 1'b0; r_pad <= 1'b0; r_empty <= 1'b0;
            r_shift  <= '0;
            r_ih     <= '0; r_iw <= '0; r_oh_m1 <= '0; r_ow_m1 <= '0;
            r_orow   <= '0; r_ocol <= '0; r_ky <= '0; r_kx <= '0; r_idx <= '0;
            r_pix    <= '0;
        end else begin
            r_tap <= '{vld: w_tap_vld, rd: o_img_rd_en, idx: r_idx};
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_stride <= i_cfg_stride; r_relu <= i_cfg_relu; r_pad <= w_pad_in;
                    r_shift  <= i_cfg_shift;  r_empty <= w_empty;
                    r_ih     <= w_ih;    r_iw <= w_iw;
                    r_oh_m1  <= w_oh_m1; r_ow_m1 <= w_ow_m1;
                    r_orow   <= '0; r_ocol <= '0; r_ky <= '0; r_kx <= '0; r_idx <= '0;
                    r_pix    <= '0;
                end
                S_FETCH: if (!r_empty) begin
                    r_idx <= w_last_tap ? '0 : r_idx + IDX_W'(1);
                    if (r_kx == KX_LAST) begin
                        r_kx <= '0;
                        r_ky <= (r_ky == KY_LAST) ? '0 : r_ky + KY_W'(1);
                    end else begin
                        r_kx <= r_kx + KX_W'(1);
                    end
                end
                S_OUT: if (i_out_ready) begin
                    r_pix <= r_pix + ADDR_W'(1);
                    if (r_ocol == r_ow_m1) begin
                        r_ocol <= '0;
                        r_orow <= r_orow + CW'(1);
                    end else begin
                        r_ocol <= r_ocol + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- MAC lanes ----------------
    logic [NUM_UNITS-1:0][TAPS-1:0][DATA_WIDTH-1:0] w_wgt;
    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]           w_q;
    logic [DATA_WIDTH-1:0]                          w_pix;
    logic                                           w_clr;

    assign w_wgt = i_w_flat;
    // border taps issue no read and contribute zero
    assign w_pix = r_tap.rd ? i_img_rd_data : '0;
    assign w_clr = (r_state == S_IDLE && i_start) || (r_state == S_OUT && i_out_ready);

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        conv_mac_unit #(.DATA_WIDTH(DATA_WIDTH), .ACC_W(ACC_W)) u_mac (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_clr   (w_clr),
            .i_en    (r_tap.vld),
            .i_pix   (w_pix),
            .i_wgt   (w_wgt[u][r_tap.idx]),
            .i_shift (r_shift),
            .i_relu  (r_relu),
            .o_q     (w_q[u])
        );
    end

    assign o_out_data = o_out_valid ? w_q : '0;
    assign o_out_addr = o_out_valid ? r_pix : '0;
endmodule

// File: tb/tb_conv_engine_mc.sv
// Directed bench for conv_engine_mc: image SRAM model, per-cycle layer runner,
// hand-computed expectations per test case.
module tb_conv_engine_mc;
    localparam int NU = 4, DW = 8, TAPS = 9, MAXW = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, cfg_stride, cfg_relu, cfg_pad;
    logic [4:0] cfg_in_w, cfg_in_h;
    logic [3:0] cfg_shift;
    logic [NU-1:0][TAPS-1:0][DW-1:0] wts;
    logic rd_en, out_valid, out_ready, busy, done;
    logic [7:0] rd_addr, rd_data, out_addr;
    logic [NU*DW-1:0] out_data;
    logic [7:0] mem [0:255];

    int n_tests = 0, n_fail = 0;

    logic [NU*DW-1:0] bq_data[$];
    int bq_addr[$], rd_q[$], exp_q[$];
    int first_valid, done_cyc, stall_cnt;
    bit got_done, stall_bad, proto_bad, busy1, busy_after;

    conv_engine_mc dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_cfg_in_w(cfg_in_w), .i_cfg_in_h(cfg_in_h), .i_cfg_stride(cfg_stride),
        .i_cfg_shift(cfg_shift), .i_cfg_relu(cfg_relu), .i_cfg_pad(cfg_pad),
        .i_w_flat(wts),
        .o_img_rd_en(rd_en), .o_img_rd_addr(rd_addr), .i_img_rd_data(rd_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_data(out_data), .o_out_addr(out_addr),
        .o_busy(busy), .o_done(done)
    );

    // 1-cycle-latency SRAM; junk when not reading so stray use shows up
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 8'h5A;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_img(input int h, input int w, input bit ramp, input int val);
        for (int a = 0; a < 256; a++) mem[a] = 8'h77;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                mem[r*MAXW + c] = ramp ? 8'(r*w + c) : 8'(val);
    endtask

    task automatic set_w(input int u, input int v);
        for (int t = 0; t < TAPS; t++) wts[u][t] = 8'(v);
    endtask

    task automatic set_all(input int v);
        for (int u = 0; u < NU; u++) set_w(u, v);
    endtask

    task automatic run_layer(input int h, input int w, input bit stride, input int shift,
                             input bit relu, input bit pad, input int stall_beat);
        logic [NU*DW-1:0] hold_d;
        int hold_a, cyc, nb;
        bq_data.delete(); bq_addr.delete(); rd_q.delete();
        first_valid = -1; done_cyc = -1; stall_cnt = 0; nb = 0; hold_a = 0; hold_d = '0;
        got_done = 0; stall_bad = 0; proto_bad = 0; busy1 = 0;
        @(negedge clk);
        cfg_in_h = 5'(h); cfg_in_w = 5'(w); cfg_stride = stride; cfg_shift = 4'(shift);
        cfg_relu = relu; cfg_pad = pad; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        while (!got_done && cyc < 3000) begin
            if (cyc == 1) busy1 = busy;
            // start and cfg churn while busy must be ignored
            start = (cyc == 5);
            if (cyc == 5) begin
                cfg_in_h = 5'd0; cfg_in_w = 5'd0; cfg_shift = 4'hF;
                cfg_relu = ~relu; cfg_stride = ~stride;
            end
            if (rd_en) begin
                rd_q.push_back(int'(rd_addr));
                if (out_valid) proto_bad = 1;
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (nb == stall_beat && stall_cnt < 10) begin
                    if (stall_cnt == 0) begin hold_d = out_data; hold_a = int'(out_addr); end
                    else if (out_data != hold_d || int'(out_addr) != hold_a) stall_bad = 1;
                    out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    if (nb == stall_beat && (out_data != hold_d || int'(out_addr) != hold_a))
                        stall_bad = 1;
                    out_ready = 1'b1;
                    bq_data.push_back(out_data);
                    bq_addr.push_back(int'(out_addr));
                    nb++;
                end
            end else begin
                out_ready = (cyc % 3 == 0);   // ready without valid is ignored
            end
            if (done) begin
                got_done = 1; done_cyc = cyc;
                if (busy || out_valid) proto_bad = 1;
                start = 1'b1;                 // start coincident with done is ignored
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        busy_after = busy | done;
    endtask

    task automatic post(input string tag, input int exp_reads, input int exp_first,
                        input int exp_done);
        check({tag, " done"},       got_done, 1);
        check({tag, " done_cyc"},   done_cyc, exp_done);
        check({tag, " first_vld"},  first_valid, exp_first);
        check({tag, " reads"},      rd_q.size(), exp_reads);
        check({tag, " busy1"},      busy1, 1);
        check({tag, " proto"},      proto_bad, 0);
        check({tag, " busy_after"}, busy_after, 0);
    endtask

    task automatic chk_beats(input string tag, input int u);
        check({tag, " beats"}, bq_data.size(), exp_q.size());
        foreach (exp_q[i]) if (i < bq_data.size()) begin
            check($sformatf("%s u%0d d%0d", tag, u, i), bq_data[i][u*DW +: DW], exp_q[i]);
            check($sformatf("%s a%0d", tag, i), bq_addr[i], i);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        cfg_in_w = '0; cfg_in_h = '0; cfg_stride = 1'b0; cfg_shift = '0;
        cfg_relu = 1'b0; cfg_pad = 1'b0; wts = '0;
        fill_img(0, 0, 1'b0, 0);
        repeat (3) @(negedge clk);
        check("rst rd_en",    rd_en, 0);
        check("rst rd_addr",  rd_addr, 0);
        check("rst valid",    out_valid, 0);
        check("rst data",     out_data, 0);
        check("rst addr",     out_addr, 0);
        check("rst busy",     busy, 0);
        check("rst done",     done, 0);
        rst = 1'b0;

        // T1: 4x4 ramp, weights 1, stride 1
        fill_img(4, 4, 1'b1, 0); set_all(1);
        run_layer(4, 4, 1'b0, 0, 1'b1, 1'b0, -1);
        exp_q = '{45, 54, 81, 90};
        chk_beats("T1", 0); chk_beats("T1", 3);
        post("T1", 36, 11, 45);

        // tap ordering: unit0 only tap (1,2), unit1 only tap (0,0)
        wts = '0; wts[0][5] = 8'd1; wts[1][0] = 8'd1;
        run_layer(4, 4, 1'b0, 0, 1'b1, 1'b0, -1);
        exp_q = '{6, 7, 10, 11};  chk_beats("TORD", 0);
        exp_q = '{0, 1, 4, 5};    chk_beats("TORD", 1);

        // T2: 5x5 of 10, stride 2
        fill_img(5, 5, 1'b0, 10); set_all(1);
        run_layer(5, 5, 1'b1, 0, 1'b1, 1'b0, -1);
        exp_q = '{90, 90, 90, 90};
        chk_beats("T2", 2);
        post("T2", 36, 11, 45);
        if (rd_q.size() == 36) begin
            check("T2 rd win1", rd_q[9], 2);
            check("T2 rd win2", rd_q[18], 30);
            check("T2 rd last", rd_q[35], 64);
        end

        // T3: saturation
        fill_img(3, 3, 1'b0, 255); set_all(127);
        run_layer(3, 3, 1'b0, 0, 1'b1, 1'b0, -1);
        exp_q = '{255}; chk_beats("T3 relu", 0);
        run_layer(3, 3, 1'b0, 0, 1'b0, 1'b0, -1);
        exp_q = '{127}; chk_beats("T3 smax", 0);
        set_all(-128);
        run_layer(3, 3, 1'b0, 0, 1'b0, 1'b0, -1);
        exp_q = '{128}; chk_beats("T3 smin", 0);
        post("T3", 9, 11, 12);

        // shift: -90 >>> 2 = -23, 90 >> 4 = 5
        fill_img(3, 3, 1'b0, 10); set_all(-1);
        run_layer(3, 3, 1'b0, 2, 1'b0, 1'b0, -1);
        exp_q = '{233}; chk_beats("TSH neg", 0);
        run_layer(3, 3, 1'b0, 2, 1'b1, 1'b0, -1);
        exp_q = '{0};   chk_beats("TSH relu", 0);
        set_all(1);
        run_layer(3, 3, 1'b0, 4, 1'b1, 1'b0, -1);
        exp_q = '{5};   chk_beats("TSH pos", 0);

        // per-unit weights on a ones image
        fill_img(3, 3, 1'b0, 1);
        for (int u = 0; u < NU; u++) set_w(u, u + 1);
        run_layer(3, 3, 1'b0, 0, 1'b0, 1'b0, -1);
        exp_q = '{18}; chk_beats("TUNIT", 1);
        exp_q = '{36}; chk_beats("TUNIT", 3);

        // T4: stall 10 cycles at beat 2
        fill_img(4, 4, 1'b1, 0); set_all(1);
        run_layer(4, 4, 1'b0, 0, 1'b1, 1'b0, 1);
        exp_q = '{45, 54, 81, 90};
        chk_beats("T4", 0);
        check("T4 hold", stall_bad, 0);
        check("T4 stall_cnt", stall_cnt, 10);
        post("T4", 36, 11, 55);

        // T5: zero padding on a 3x3 ones image
        fill_img(3, 3, 1'b0, 1); set_all(1);
        run_layer(3, 3, 1'b0, 0, 1'b1, 1'b1, -1);
`ifdef ZERO_PAD_EN
        exp_q = '{4, 6, 4, 6, 9, 6, 4, 6, 4};
        chk_beats("T5", 0);
        post("T5", 49, 11, 100);
`else
        exp_q = '{9};
        chk_beats("T5 nopad", 0);
        post("T5 nopad", 9, 11, 12);
`endif

        // T6: reset mid-FETCH, then degenerate layer
        fill_img(4, 4, 1'b1, 0);
        @(negedge clk);
        cfg_in_h = 5'd4; cfg_in_w = 5'd4; cfg_stride = 1'b0; cfg_pad = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("T6 rd_en",   rd_en, 0);
        check("T6 rd_addr", rd_addr, 0);
        check("T6 valid",   out_valid, 0);
        check("T6 busy",    busy, 0);
        check("T6 done",    done, 0);
        rst = 1'b0;
        run_layer(2, 4, 1'b0, 0, 1'b1, 1'b0, -1);
        check("T6 beats", bq_data.size(), 0);
        post("T6", 0, -1, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
